line_steer_ctrl: RTL



---
 rtl/line_steer_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/line_steer_ctrl.sv
// Line-following steering controller. It synchronises and debounces the leading sensor
// bank, classifies it into a 4-bit steering code, and resolves lost-line events.
module line_steer_ctrl #(
    parameter int N_SENS           = 4,
    parameter int DEBOUNCE_CYCLES  = 5000,
    parameter int INTERSECT_CYCLES = 30000000,
    parameter int SENS_INV         = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              direction,
    input  logic [N_SENS-1:0] front_sens,
    input  logic [N_SENS-1:0] rear_sens,
    input  logic [1:0]        mid_sens,
    output logic [3:0]        dir,
    output logic              dir_strobe,
    output logic              at_intersect,
    output logic [2:0]        state_dbg
);
    localparam int NIN  = 2*N_SENS + 2;
    localparam int HALF = N_SENS / 2;
    localparam int CW   = $clog2(N_SENS) + 1;
    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int IW   = $clog2(INTERSECT_CYCLES + 1);

    localparam logic [3:0] C_PROCEED  = 4'b0000;
    localparam logic [3:0] C_VEER_R   = 4'b1001;
    localparam logic [3:0] C_HARD_R   = 4'b1010;
    localparam logic [3:0] C_NINETY_R = 4'b1011;
    localparam logic [3:0] C_VEER_L   = 4'b0101;
    localparam logic [3:0] C_HARD_L   = 4'b0110;
    localparam logic [3:0] C_NINETY_L = 4'b0111;
    localparam logic [3:0] C_STOP     = 4'b1111;

    typedef enum logic [2:0] {
        S_TRACK         = 3'd0,
        S_DEBOUNCE      = 3'd1,
        S_CLASSIFY      = 3'd2,
        S_CHK_INTERSECT = 3'd3,
        S_HALT          = 3'd4
    } state_t;

    state_t            state, state_n;
    logic [NIN-1:0]    raw_pol, sync1, sync2;
    logic [N_SENS-1:0] front_sync, rear_sync, lead, prev_lead, snap, snap_n;
    logic [1:0]        mid_sync;
    logic              direction_q, dir_chg, is_ninety, at_n;
    logic [3:0]        dir_n, class_code;
    logic [DW-1:0]     dcnt, dcnt_n;
    logic [IW-1:0]     icnt, icnt_n;
    logic [CW-1:0]     cnt_l, cnt_r, diff;

    function automatic logic [CW-1:0] popcnt(input logic [HALF-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < HALF; i++) c = c + CW'(v[i]);
        return c;
    endfunction

    // Inversion sits ahead of the first synchroniser flop so everything downstream sees 1 = tape.
    assign raw_pol    = (SENS_INV != 0) ? ~{mid_sens, rear_sens, front_sens}
                                        :  {mid_sens, rear_sens, front_sens};
    assign front_sync = sync2[N_SENS-1:0];
    assign rear_sync  = sync2[2*N_SENS-1:N_SENS];
    assign mid_sync   = sync2[NIN-1:2*N_SENS];
    assign lead       = direction ? front_sync : rear_sync;
    assign dir_chg    = (direction != direction_q);
    assign is_ninety  = (dir == C_NINETY_L) || (dir == C_NINETY_R);
    assign state_dbg  = state;

    assign cnt_l = popcnt(lead[HALF-1:0]);
    assign cnt_r = popcnt(lead[N_SENS-1:HALF]);
    assign diff  = (cnt_r > cnt_l) ? (cnt_r - cnt_l) : (cnt_l - cnt_r);

    always_comb begin
        class_code = C_PROCEED;
        if (diff != '0) begin
            if (diff < CW'(HALF)) class_code = (cnt_r > cnt_l) ? C_VEER_R : C_VEER_L;
            else                  class_code = (cnt_r > cnt_l) ? C_HARD_R : C_HARD_L;
        end
    end

    always_comb begin
        state_n = state;
        dir_n   = dir;
        dcnt_n  = dcnt;
        icnt_n  = icnt;
        snap_n  = snap;
        at_n    = 1'b0;
        if (!enable) begin
            state_n = S_TRACK;
            dir_n   = C_STOP;
            dcnt_n  = '0;
            icnt_n  = '0;
        end else begin
            case (state)
                S_TRACK: begin
                    if (lead != prev_lead || dir_chg) begin
                        state_n = S_DEBOUNCE;
                        snap_n  = prev_lead;
                        dcnt_n  = '0;
                    end
                end
                S_DEBOUNCE: begin
                    if (dir_chg) begin
                        dcnt_n = '0;
                    end else begin
                        dcnt_n = dcnt + DW'(1);
                        if (lead == snap)                           state_n = S_TRACK;
                        else if (dcnt == DW'(DEBOUNCE_CYCLES - 1))  state_n = S_CLASSIFY;
                    end
                end
                S_CLASSIFY: begin
                    if (lead == '0) begin
                        state_n = S_CHK_INTERSECT;
                        icnt_n  = '0;
                    end else begin
                        dir_n   = class_code;
                        state_n = S_TRACK;
                    end
                end
                S_CHK_INTERSECT: begin
                    if (lead != '0) begin
                        state_n = S_CLASSIFY;
                    end else if (mid_sync == 2'b11 || icnt == IW'(INTERSECT_CYCLES)) begin
                        dir_n   = C_STOP;
                        at_n    = 1'b1;
                        state_n = S_HALT;
                    end else if (mid_sync == 2'b01) begin
                        dir_n = C_NINETY_L;
                    end else if (mid_sync == 2'b10) begin
                        dir_n = C_NINETY_R;
                    end else if (!is_ninety) begin
                        // A committed 90-degree turn is held; only straight running counts toward the timeout.
                        dir_n  = C_PROCEED;
                        icnt_n = icnt + IW'(1);
                    end
                end
                S_HALT: begin
                    if (lead != '0) state_n = S_TRACK;
                end
                default: state_n = S_TRACK;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1        <= '0;
            sync2        <= '0;
            prev_lead    <= '0;
            direction_q  <= 1'b0;
            state        <= S_TRACK;
            dir          <= C_STOP;
            dir_strobe   <= 1'b0;
            at_intersect <= 1'b0;
            dcnt         <= '0;
            icnt         <= '0;
            snap         <= '0;
        end else begin
            sync1        <= raw_pol;
            sync2        <= sync1;
            prev_lead    <= lead;
            direction_q  <= direction;
            state        <= state_n;
            dir          <= dir_n;
            dir_strobe   <= (dir_n != dir);
            at_intersect <= at_n;
            dcnt         <= dcnt_n;
            icnt         <= icnt_n;
            snap         <= snap_n;
        end
    end
endmodule
